// File: rtl/hazard_scoreboard_unit.sv
// Forwarding and hazard unit for a 5-stage pipeline with a multi-cycle multiplier.
// Forwarding selects and stall are combinational; a shift-register scoreboard tracks in-flight multiplies.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned MUL_LAT       = 3,
  parameter int unsigned MUL_PIPELINED = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  use_rs1_ID,
  input  logic                  use_rs2_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic                  reg_write_ID,
  input  logic                  mul_ID,
  input  logic [REG_ADDR_W-1:0] rs1_EX,
  input  logic [REG_ADDR_W-1:0] rs2_EX,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic                  reg_write_EX,
  input  logic                  mem_2_reg_EX,
  input  logic                  mul_EX,
  input  logic [REG_ADDR_W-1:0] rd_MEM,
  input  logic                  reg_write_MEM,
  input  logic                  mem_2_reg_MEM,
  input  logic [REG_ADDR_W-1:0] rd_WB,
  input  logic                  reg_write_WB,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall_IF_ID,
  output logic                  bubble_ID_EX,
  output logic                  mul_busy,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic [MUL_LAT-1:0]    v_q, v_d;
  logic [REG_ADDR_W-1:0] rd_q [MUL_LAT];
  logic [REG_ADDR_W-1:0] rd_d [MUL_LAT];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ex_dst_ok, id_uses_ex, load_use, mul_raw, mul_waw, structural, stall;

  // EX/MEM ALU result beats MEM/WB; loads in MEM are not yet available.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic                  rw_mem,
                                         input logic                  m2r_mem,
                                         input logic [REG_ADDR_W-1:0] rd_mem,
                                         input logic                  rw_wb,
                                         input logic [REG_ADDR_W-1:0] rd_wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (rw_mem && !m2r_mem && rd_mem == rs) sel = 2'b10;
      else if (rw_wb && rd_wb == rs)          sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_sel_a = fwd_sel(rs1_EX, reg_write_MEM, mem_2_reg_MEM, rd_MEM, reg_write_WB, rd_WB);
  assign fwd_sel_b = fwd_sel(rs2_EX, reg_write_MEM, mem_2_reg_MEM, rd_MEM, reg_write_WB, rd_WB);
  assign mul_busy  = |v_q;

  // Hazard detection; the last scoreboard entry is in WB and forwards, so it never raises RAW.
  always_comb begin
    ex_dst_ok  = reg_write_EX && (rd_EX != '0);
    id_uses_ex = (use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX);
    load_use   = mem_2_reg_EX && ex_dst_ok && id_uses_ex;
    mul_raw    = mul_EX && ex_dst_ok && id_uses_ex;
    mul_waw    = reg_write_ID && (rd_ID != '0) && mul_EX && reg_write_EX && (rd_EX == rd_ID);
    for (int k = 0; k < int'(MUL_LAT); k++) begin
      if (v_q[k] && reg_write_ID && (rd_ID != '0) && rd_q[k] == rd_ID) mul_waw = 1'b1;
      if ((k < int'(MUL_LAT) - 1) && v_q[k] &&
          ((use_rs1_ID && rs1_ID == rd_q[k]) || (use_rs2_ID && rs2_ID == rd_q[k])))
        mul_raw = 1'b1;
    end
    structural = (MUL_PIPELINED == 0) && mul_ID && (mul_EX || mul_busy);
    stall      = load_use || mul_raw || mul_waw || structural;
  end

  assign stall_IF_ID  = stall;
  assign bubble_ID_EX = stall;
  assign stall_cycles = cnt_q;

  // Scoreboard shifts every cycle; a bubble in EX simply enters as an invalid entry.
  always_comb begin
    v_d[0]  = mul_EX && ex_dst_ok;
    rd_d[0] = rd_EX;
    for (int k = 1; k < int'(MUL_LAT); k++) begin
      v_d[k]  = v_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < int'(MUL_LAT); k++) rd_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < int'(MUL_LAT); k++) rd_q[k] <= rd_d[k];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios then random traffic, checked against
// an issue-history model; a second instance covers non-pipelined multiply and a 2-bit counter.
module tb_hazard_scoreboard_unit;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic       use_rs1_ID, use_rs2_ID, reg_write_ID, mul_ID;
  logic       reg_write_EX, mem_2_reg_EX, mul_EX, reg_write_MEM, mem_2_reg_MEM, reg_write_WB;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic       st0, bb0, busy0, st1, bb1, busy1;
  logic [15:0] cnt0_o;
  logic [1:0]  cnt1_o;

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MUL_LAT(LAT), .MUL_PIPELINED(1), .CNT_W(16)) dut0 (
    .clk(clk), .arst_n(arst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID),
    .use_rs2_ID(use_rs2_ID), .rd_ID(rd_ID), .reg_write_ID(reg_write_ID), .mul_ID(mul_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .reg_write_EX(reg_write_EX),
    .mem_2_reg_EX(mem_2_reg_EX), .mul_EX(mul_EX), .rd_MEM(rd_MEM), .reg_write_MEM(reg_write_MEM),
    .mem_2_reg_MEM(mem_2_reg_MEM), .rd_WB(rd_WB), .reg_write_WB(reg_write_WB),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_IF_ID(st0), .bubble_ID_EX(bb0),
    .mul_busy(busy0), .stall_cycles(cnt0_o));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MUL_LAT(LAT), .MUL_PIPELINED(0), .CNT_W(2)) dut1 (
    .clk(clk), .arst_n(arst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID),
    .use_rs2_ID(use_rs2_ID), .rd_ID(rd_ID), .reg_write_ID(reg_write_ID), .mul_ID(mul_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .reg_write_EX(reg_write_EX),
    .mem_2_reg_EX(mem_2_reg_EX), .mul_EX(mul_EX), .rd_MEM(rd_MEM), .reg_write_MEM(reg_write_MEM),
    .mem_2_reg_MEM(mem_2_reg_MEM), .rd_WB(rd_WB), .reg_write_WB(reg_write_WB),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_IF_ID(st1), .bubble_ID_EX(bb1),
    .mul_busy(busy1), .stall_cycles(cnt1_o));

  int checks = 0;
  int errors = 0;

  // Model: which tracked multiply issued in which cycle, plus the last cycle reset was low.
  int         cyc = 0;
  int         last_rst = -1;
  bit         hist_v [4096];
  logic [4:0] hist_rd[4096];
  int         cnt0 = 0, cnt1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit inflight(input int k);
    int c = cyc - 1 - k;
    return (c >= 0) && (c > last_rst) && hist_v[c];
  endfunction

  function automatic logic [4:0] inflight_rd(input int k);
    int c = cyc - 1 - k;
    return (c >= 0) ? hist_rd[c] : 5'd0;
  endfunction

  function automatic bit id_reads(input logic [4:0] r);
    return (use_rs1_ID && rs1_ID == r) || (use_rs2_ID && rs2_ID == r);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (reg_write_MEM && !mem_2_reg_MEM && rd_MEM == rs) return 2'b10;
    if (reg_write_WB && rd_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_busy();
    bit b = 0;
    for (int k = 0; k < LAT; k++) if (inflight(k)) b = 1;
    return b;
  endfunction

  function automatic bit exp_stall(input bit pipelined);
    bit ex_d = reg_write_EX && rd_EX != 5'd0;
    bit s;
    s = ex_d && (mem_2_reg_EX || mul_EX) && id_reads(rd_EX);
    if (reg_write_ID && rd_ID != 5'd0 && mul_EX && ex_d && rd_EX == rd_ID) s = 1;
    for (int k = 0; k < LAT; k++) begin
      // A multiply issued LAT cycles ago is in WB this cycle and is forwarded, not stalled on.
      if (k < LAT - 1 && inflight(k) && id_reads(inflight_rd(k))) s = 1;
      if (inflight(k) && reg_write_ID && rd_ID != 5'd0 && inflight_rd(k) == rd_ID) s = 1;
    end
    if (!pipelined && mul_ID && (mul_EX || exp_busy())) s = 1;
    return s;
  endfunction

  task automatic tick();
    bit e0, e1;
    @(negedge clk);
    if (!arst_n) begin
      last_rst = cyc;
      cnt0 = 0;
      cnt1 = 0;
    end
    e0 = exp_stall(1'b1);
    e1 = exp_stall(1'b0);
    chk("fwd_a", 32'(fa0), 32'(exp_fwd(rs1_EX)));
    chk("fwd_b", 32'(fb0), 32'(exp_fwd(rs2_EX)));
    chk("fwd_a_np", 32'(fa1), 32'(exp_fwd(rs1_EX)));
    chk("stall", 32'(st0), 32'(e0));
    chk("bubble", 32'(bb0), 32'(e0));
    chk("busy", 32'(busy0), 32'(exp_busy()));
    chk("cnt", 32'(cnt0_o), 32'(cnt0));
    chk("stall_np", 32'(st1), 32'(e1));
    chk("bubble_np", 32'(bb1), 32'(e1));
    chk("busy_np", 32'(busy1), 32'(exp_busy()));
    chk("cnt_np", 32'(cnt1_o), 32'(cnt1));
    @(posedge clk);
    hist_v[cyc]  = arst_n && mul_EX && reg_write_EX && rd_EX != 5'd0;
    hist_rd[cyc] = rd_EX;
    if (arst_n) begin
      if (e0 && cnt0 < 65535) cnt0++;
      if (e1 && cnt1 < 3) cnt1++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    {rs1_ID, rs2_ID, rd_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB} = '0;
    {use_rs1_ID, use_rs2_ID, reg_write_ID, mul_ID} = '0;
    {reg_write_EX, mem_2_reg_EX, mul_EX, reg_write_MEM, mem_2_reg_MEM, reg_write_WB} = '0;
  endtask

  task automatic rst_pulse();
    idle();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    idle();
    arst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_cnt", 32'(cnt0_o), 0);
    chk("rst_stall", 32'(st0), 0);
    tick();
    arst_n = 1'b1;
    tick();

    // ALU x5 in MEM and WB: MEM wins; source x0 never forwards.
    rd_MEM = 5; reg_write_MEM = 1; rd_WB = 5; reg_write_WB = 1; rs1_EX = 5; rs2_EX = 5;
    #2; chk("t1_fwd_a", 32'(fa0), 2); chk("t1_fwd_b", 32'(fb0), 2);
    tick();
    rs1_EX = 0; rd_MEM = 0; rd_WB = 0;
    #2; chk("t1_fwd_x0", 32'(fa0), 0);
    tick();

    // Load-use on x6: one stall, then WB forwards.
    idle(); rd_EX = 6; reg_write_EX = 1; mem_2_reg_EX = 1; use_rs2_ID = 1; rs2_ID = 6;
    #2; chk("t2_stall", 32'(st0), 1);
    tick();
    idle(); rd_WB = 6; reg_write_WB = 1; rs2_EX = 6;
    #2; chk("t2_fwd_b", 32'(fb0), 1); chk("t2_cnt", 32'(cnt0_o), 1); chk("t2_nostall", 32'(st0), 0);
    tick();

    // mul x7 with dependent in ID: three stall cycles then WB forwarding.
    rst_pulse();
    idle(); mul_EX = 1; reg_write_EX = 1; rd_EX = 7; use_rs1_ID = 1; rs1_ID = 7;
    tick();
    idle(); use_rs1_ID = 1; rs1_ID = 7;
    tick(); tick();
    rd_WB = 7; reg_write_WB = 1; rs1_EX = 7;
    #2; chk("t3_nostall", 32'(st0), 0); chk("t3_cnt", 32'(cnt0_o), 3); chk("t3_fwd", 32'(fa0), 1);
    tick();

    // Back-to-back muls: only the non-pipelined instance holds the second.
    rst_pulse();
    idle(); mul_EX = 1; reg_write_EX = 1; rd_EX = 9; mul_ID = 1; reg_write_ID = 1; rd_ID = 10;
    #2; chk("t4_pipe", 32'(st0), 0); chk("t4_np", 32'(st1), 1);
    tick();
    idle(); mul_ID = 1; reg_write_ID = 1; rd_ID = 10;
    tick(); tick(); tick();
    #2; chk("t4_busy_clr", 32'(busy1), 0); chk("t4_np_free", 32'(st1), 0);
    tick();
    idle(); mul_EX = 1; reg_write_EX = 1; rd_EX = 0;
    tick();
    idle();
    #2; chk("t4_x0_untracked", 32'(busy0), 0);
    tick();

    // WAW on x8, then a reset drops the pending multiply at once.
    idle(); mul_EX = 1; reg_write_EX = 1; rd_EX = 8; reg_write_ID = 1; rd_ID = 8;
    #2; chk("t5_waw_ex", 32'(st0), 1);
    tick();
    idle(); reg_write_ID = 1; rd_ID = 8;
    #2; chk("t5_waw_sb", 32'(st0), 1); chk("t5_busy", 32'(busy0), 1);
    tick();
    arst_n = 1'b0;
    #2; chk("t5_rst_busy", 32'(busy0), 0); chk("t5_rst_stall", 32'(st0), 0);
    tick();
    arst_n = 1'b1;
    #2; chk("t5_after_rst", 32'(st0), 0);
    tick();

    // Five load-use cycles: the 2-bit counter saturates at 3.
    rst_pulse();
    idle(); rd_EX = 6; reg_write_EX = 1; mem_2_reg_EX = 1; use_rs1_ID = 1; rs1_ID = 6;
    repeat (5) tick();
    idle();
    #2; chk("t6_cnt16", 32'(cnt0_o), 5); chk("t6_sat", 32'(cnt1_o), 3);
    tick();

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      arst_n        = ($urandom_range(0, 63) != 0);
      rs1_ID        = 5'($urandom_range(0, 3));
      rs2_ID        = 5'($urandom_range(0, 3));
      rd_ID         = 5'($urandom_range(0, 3));
      use_rs1_ID    = 1'($urandom);
      use_rs2_ID    = 1'($urandom);
      reg_write_ID  = 1'($urandom);
      mul_ID        = ($urandom_range(0, 3) == 0);
      rs1_EX        = 5'($urandom_range(0, 3));
      rs2_EX        = 5'($urandom_range(0, 3));
      rd_EX         = 5'($urandom_range(0, 3));
      reg_write_EX  = 1'($urandom);
      mem_2_reg_EX  = ($urandom_range(0, 3) == 0);
      mul_EX        = ($urandom_range(0, 2) == 0);
      rd_MEM        = 5'($urandom_range(0, 3));
      reg_write_MEM = 1'($urandom);
      mem_2_reg_MEM = 1'($urandom);
      rd_WB         = 5'($urandom_range(0, 3));
      reg_write_WB  = 1'($urandom);
      tick();
    end
    arst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
